jtag_scan_sequencer: RTL and testbench
======================================

// Module: jtag_scan_sequencer
// PURPOSE
//  Converts IR/DR scan requests into bit-level JTAG pin activity on TCK/TMS/TDI/TRSTn and returns the TDO bits.
//  Walks the IEEE 1149.1 TAP state machine and divides the system clock down to TCK.
//  Sits between a debug-transport front end and the JTAG pins of the DUT (or the simulation JTAG bridge).
//  Serialises one scan at a time.
// PARAMETERS
//  CLK_DIV   4    clock cycles per TCK half-period (>=1)
//  MAX_BITS  64   widest scan supported; width of req_data/resp_data
//  LEN_W     7    width of req_len; must hold MAX_BITS
// PORTS
//  clock       in   1         system clock; the only clock
//  reset       in   1         asynchronous, active-high reset
//  req_valid   in   1         scan request valid
//  req_ready   out  1         request accepted when req_valid & req_ready
//  req_ir      in   1         1 = IR scan, 0 = DR scan
//  req_len     in   LEN_W     number of bits to shift
//  req_data    in   MAX_BITS  TDI bits, LSB shifted first
//  resp_valid  out  1         captured data valid; held until resp_ready
//  resp_ready  in   1         response consumed when resp_valid & resp_ready
//  resp_data   out  MAX_BITS  TDO bits; bit i = i-th bit shifted; bits >= len are 0
//  busy        out  1         high whenever the FSM is not in IDLE
//  jtag_TCK    out  1         test clock
//  jtag_TMS    out  1         test mode select
//  jtag_TDI    out  1         test data in
//  jtag_TRSTn  out  1         TAP reset, active low
//  jtag_TDO    in   1         test data out from target
// BEHAVIOUR
//  Reset values: TCK=0, TMS=1, TDI=0, req_ready=0, resp_valid=0, resp_data=0, busy=1, TRSTn per CONFIGURATION.
//  TCK period: low for CLK_DIV cycles, then high for CLK_DIV cycles.
//   - TMS/TDI update on the clock edge that drives TCK low.
//   - TDO is sampled on the clock edge that drives TCK high.
//  FSM: TLR -> IDLE -> PRE -> SHIFT -> POST -> RESP -> IDLE.
//   - TLR: 5 TCK with TMS=1, then 1 TCK with TMS=0 (Run-Test/Idle); entered once after reset.
//   - IDLE: TCK held 0, TMS=0. req_ready=1 only here.
//   - PRE: DR uses TMS 1,0,0; IR uses TMS 1,1,0,0 (ends in Shift-xR).
//   - SHIFT: len TCKs. TDI = req_data[i]. TMS=0 except TMS=1 on the last bit (Exit1).
//   - POST: TMS 1 (Update), then TMS 0 (Run-Test/Idle).
//   - RESP: resp_valid=1 with data stable until resp_ready; then go to IDLE; req_ready rises the next cycle.
//  Request fields are registered on acceptance; later input changes are ignored.
//  req_len=0: no TCK activity; RESP is entered the cycle after acceptance with resp_data=0.
//  req_len>MAX_BITS: clamped to MAX_BITS.
//  Bit counter is LEN_W wide and counts down from len; SHIFT exits when the counter reaches 1.
//  resp_ready while resp_valid=0 is ignored.
//  Async reset mid-scan: all state aborts immediately; outputs take reset values; TLR re-runs.
// CONFIGURATION
//  JTAG_SEQ_TRST_EN defined:
//   - jtag_TRSTn=0 during reset and for 4 TCK periods after reset deasserts; TCK toggles, TMS=1.
//   - Then TRSTn=1 and TLR runs.
//  JTAG_SEQ_TRST_EN undefined: jtag_TRSTn tied 1; TLR alone resets the TAP.
// TESTING
//  - Reset release, CLK_DIV=4 -> 6 TCK periods of 8 cycles; TMS=1,1,1,1,1,0; then busy=0, req_ready=1.
//  - DR scan, len=8, data=0xA5, TDO loopback of TDI -> TMS 1,0,0,0x7,1,1,0; resp_data=0xA5.
//  - IR scan, len=5, data=0x11, TDO held 1 -> 4 PRE TCKs (TMS 1,1,0,0); 5 shift TCKs; resp_data=0x1F.
//  - len=0 request -> no TCK edge; resp_valid the cycle after accept; resp_data=0.
//  - resp_ready=0 for 20 cycles -> resp_valid/resp_data stable; req_ready=0; no TCK.
//  - reset asserted mid-SHIFT of len=64 -> TCK=0, TMS=1 at once; full TLR after release.
//  - With JTAG_SEQ_TRST_EN: TRSTn low 4 TCKs after reset, then TLR.

Source files
------------

// File: rtl/jtag_scan_sequencer.sv
// JTAG scan sequencer: serialises IR/DR scan requests onto TCK/TMS/TDI and gathers TDO bits.
// Define JTAG_SEQ_TRST_EN to drive a TRSTn pulse of 4 TCK periods before the TLR walk.
module jtag_scan_sequencer #(
  parameter int CLK_DIV  = 4,
  parameter int MAX_BITS = 64,
  parameter int LEN_W    = 7
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_ir,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [MAX_BITS-1:0] req_data,
  output logic                resp_valid,
  input  logic                resp_ready,
  output logic [MAX_BITS-1:0] resp_data,
  output logic                busy,
  output logic                jtag_TCK,
  output logic                jtag_TMS,
  output logic                jtag_TDI,
  output logic                jtag_TRSTn,
  input  logic                jtag_TDO
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (MAX_BITS > 1) ? $clog2(MAX_BITS) : 1;

  typedef enum logic [2:0] {
    S_TRST, S_TLR, S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP
  } state_t;

`ifdef JTAG_SEQ_TRST_EN
  localparam state_t RESET_STATE = S_TRST;
`else
  localparam state_t RESET_STATE = S_TLR;
`endif

  state_t              state, state_next;
  logic [DIV_W-1:0]    div_cnt;
  logic [2:0]          step, step_next;
  logic [LEN_W-1:0]    bit_cnt, bit_cnt_next, len_reg, len_clamped;
  logic                ir_reg;
  logic [MAX_BITS-1:0] data_reg, data_shifted, cap_reg;
  logic [IDX_W-1:0]    cap_idx;
  logic                tck_active, tick, rise, fall, last_step, accept;
  logic                tms_next, tdi_next;

  assign accept      = req_valid && (state == S_IDLE);
  assign len_clamped = (req_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : req_len;
  assign tck_active  = state inside {S_TRST, S_TLR, S_PRE, S_SHIFT, S_POST};
  assign tick        = tck_active && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise        = tick && !jtag_TCK;
  assign fall        = tick && jtag_TCK;
  assign cap_idx     = IDX_W'(len_reg - bit_cnt);
  assign resp_data   = cap_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= RESET_STATE;
    else       state <= state_next;
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      S_TRST:  if (fall && last_step) state_next = S_TLR;
      S_TLR:   if (fall && last_step) state_next = S_IDLE;
      S_IDLE:  if (accept) state_next = (len_clamped == '0) ? S_RESP : S_PRE;
      S_PRE:   if (fall && last_step) state_next = S_SHIFT;
      S_SHIFT: if (fall && last_step) state_next = S_POST;
      S_POST:  if (fall && last_step) state_next = S_RESP;
      S_RESP:  if (resp_ready) state_next = S_IDLE;
      default: state_next = RESET_STATE;
    endcase
  end

  // Per-period sequencing: the pin values computed here are applied on the edge that drives TCK low.
  always_comb begin
    last_step = 1'b0;
    case (state)
      S_TRST:  last_step = (step == 3'd3);
      S_TLR:   last_step = (step == 3'd5);
      S_PRE:   last_step = (step == (ir_reg ? 3'd3 : 3'd2));
      S_SHIFT: last_step = (bit_cnt == LEN_W'(1));
      S_POST:  last_step = (step == 3'd1);
      default: last_step = 1'b0;
    endcase

    if (state_next != state) step_next = '0;
    else if (fall)           step_next = step + 3'd1;
    else                     step_next = step;

    if (accept)                       bit_cnt_next = len_clamped;
    else if (fall && state == S_SHIFT) bit_cnt_next = bit_cnt - LEN_W'(1);
    else                              bit_cnt_next = bit_cnt;

    data_shifted = (state == S_SHIFT) ? (data_reg >> 1) : data_reg;

    tms_next = 1'b0;
    case (state_next)
      S_TRST:  tms_next = 1'b1;
      S_TLR:   tms_next = (step_next != 3'd5);
      S_PRE:   tms_next = (step_next == 3'd0) || (ir_reg && step_next == 3'd1);
      S_SHIFT: tms_next = (bit_cnt_next == LEN_W'(1));
      S_POST:  tms_next = (step_next == 3'd0);
      default: tms_next = 1'b0;
    endcase

    tdi_next = (state_next == S_SHIFT) ? data_shifted[0] : 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      div_cnt    <= '0;
      step       <= '0;
      bit_cnt    <= '0;
      len_reg    <= '0;
      ir_reg     <= 1'b0;
      data_reg   <= '0;
      cap_reg    <= '0;
      jtag_TCK   <= 1'b0;
      jtag_TMS   <= 1'b1;
      jtag_TDI   <= 1'b0;
      busy       <= 1'b1;
      req_ready  <= 1'b0;
      resp_valid <= 1'b0;
    end else begin
      div_cnt <= (tick || !tck_active) ? '0 : div_cnt + DIV_W'(1);
      if (tick) jtag_TCK <= ~jtag_TCK;
      step    <= step_next;
      bit_cnt <= bit_cnt_next;
      if (fall || accept) begin
        jtag_TMS <= tms_next;
        jtag_TDI <= tdi_next;
      end
      if (accept) begin
        len_reg  <= len_clamped;
        ir_reg   <= req_ir;
        data_reg <= req_data;
        cap_reg  <= '0;
      end else begin
        if (fall && state == S_SHIFT) data_reg <= data_shifted;
        if (rise && state == S_SHIFT) cap_reg[cap_idx] <= jtag_TDO;
      end
      busy       <= (state_next != S_IDLE);
      req_ready  <= (state_next == S_IDLE);
      resp_valid <= (state_next == S_RESP);
    end
  end

`ifdef JTAG_SEQ_TRST_EN
  logic trst_n;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) trst_n <= 1'b0;
    else       trst_n <= (state_next != S_TRST);
  end
  assign jtag_TRSTn = trst_n;
`else
  assign jtag_TRSTn = 1'b1;
`endif

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Directed bench for jtag_scan_sequencer: scoreboarded responses plus a TCK-edge pin log.
`timescale 1ns/1ps
module tb_jtag_scan_sequencer;

  localparam int CLK_DIV  = 4;
  localparam int MAX_BITS = 64;
  localparam int LEN_W    = 7;
  localparam int HALF_NS  = 5;
`ifdef JTAG_SEQ_TRST_EN
  localparam int N_TRST = 4;
`else
  localparam int N_TRST = 0;
`endif

  logic                clock = 1'b0;
  logic                reset;
  logic                req_valid, req_ready, req_ir;
  logic [LEN_W-1:0]    req_len;
  logic [MAX_BITS-1:0] req_data, resp_data;
  logic                resp_valid, resp_ready, busy;
  logic                jtag_TCK, jtag_TMS, jtag_TDI, jtag_TRSTn, jtag_TDO;

  int tdo_mode;  // 0: loopback of TDI, 1: held high, 2: held low
  assign jtag_TDO = (tdo_mode == 0) ? jtag_TDI : (tdo_mode == 1);

  jtag_scan_sequencer #(.CLK_DIV(CLK_DIV), .MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_ir(req_ir),
    .req_len(req_len), .req_data(req_data),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .busy(busy),
    .jtag_TCK(jtag_TCK), .jtag_TMS(jtag_TMS), .jtag_TDI(jtag_TDI),
    .jtag_TRSTn(jtag_TRSTn), .jtag_TDO(jtag_TDO)
  );

  always #HALF_NS clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] sb_q[$];
  bit          tms_q[$], tdi_q[$], trst_q[$];
  time         rise_t[$], fall_t[$];

  always @(posedge jtag_TCK) begin
    tms_q.push_back(jtag_TMS);
    tdi_q.push_back(jtag_TDI);
    trst_q.push_back(jtag_TRSTn);
    rise_t.push_back($time);
  end
  always @(negedge jtag_TCK) fall_t.push_back($time);

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_logs();
    tms_q.delete(); tdi_q.delete(); trst_q.delete(); rise_t.delete(); fall_t.delete();
  endtask

  function automatic logic [63:0] exp_resp(input int mode, input int len, input logic [63:0] d);
    logic [63:0] mask;
    mask = (len >= 64) ? '1 : ((64'd1 << len) - 64'd1);
    if (mode == 0)      return d & mask;
    else if (mode == 1) return mask;
    else                return 64'd0;
  endfunction

  task automatic pack_logs(output logic [127:0] t, output logic [127:0] d, output logic [127:0] r);
    t = '0; d = '0; r = '0;
    for (int i = 0; i < tms_q.size() && i < 128; i++) begin
      if (tms_q[i])  t |= 128'(1) << i;
      if (tdi_q[i])  d |= 128'(1) << i;
      if (trst_q[i]) r |= 128'(1) << i;
    end
  endtask

  task automatic wait_ready(input string tag, input int budget, output int cycles);
    cycles = 0;
    while (!req_ready && cycles < budget) begin
      @(posedge clock); @(negedge clock); cycles++;
    end
    check({tag, "_ready_timeout"}, 128'(req_ready), 128'(1));
  endtask

  task automatic wait_resp(input string tag, input int budget, output logic [63:0] got);
    int k;
    k = 0;
    while (!resp_valid && k < budget) begin
      @(posedge clock); @(negedge clock); k++;
    end
    check({tag, "_resp_timeout"}, 128'(resp_valid), 128'(1));
    got = resp_data;
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 128'(1), 128'(0));
    else                  check({tag, "_resp_data"}, 128'(resp_data), 128'(sb_q.pop_front()));
  endtask

  // Drive one request at a negedge with req_ready high, then scramble the inputs after acceptance.
  task automatic send_req(input bit ir, input int len, input logic [63:0] d);
    int len_eff;
    len_eff = (len > MAX_BITS) ? MAX_BITS : len;
    sb_q.push_back(exp_resp(tdo_mode, len_eff, d));
    req_ir = ir; req_len = LEN_W'(len); req_data = d; req_valid = 1'b1;
    @(posedge clock); @(negedge clock);
    req_valid = 1'b0; req_ir = ~ir; req_len = 7'd3; req_data = ~d;
  endtask

  task automatic consume(input string tag);
    resp_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    resp_ready = 1'b0;
    check({tag, "_valid_drop"}, 128'(resp_valid), 128'(0));
    check({tag, "_ready_back"}, 128'(req_ready), 128'(1));
  endtask

  task automatic check_tlr(input string tag, input int cycles);
    logic [127:0] t, d, r, et, er;
    et = ((128'(1) << (N_TRST + 5)) - 128'(1));
    er = ((128'(1) << (N_TRST + 6)) - 128'(1)) & ~((128'(1) << N_TRST) - 128'(1));
    pack_logs(t, d, r);
    check({tag, "_cycles"}, 128'(cycles), 128'((N_TRST + 6) * 2 * CLK_DIV));
    check({tag, "_nrise"}, 128'(tms_q.size()), 128'(N_TRST + 6));
    check({tag, "_tms"}, t, et);
    check({tag, "_trstn"}, r, er);
    check({tag, "_tdi"}, d, 128'(0));
    check({tag, "_busy"}, 128'(busy), 128'(0));
  endtask

  task automatic check_seq(input string tag, input bit ir, input int len, input logic [63:0] dat);
    logic [127:0] t, d, r, et, ed;
    int n;
    et = '0; ed = '0; n = 0;
    et |= 128'(1) << n; n++;
    if (ir) begin et |= 128'(1) << n; n++; end
    n += 2;
    for (int i = 0; i < len; i++) begin
      if (i == len - 1) et |= 128'(1) << n;
      if (dat[i])       ed |= 128'(1) << n;
      n++;
    end
    et |= 128'(1) << n; n += 2;
    pack_logs(t, d, r);
    check({tag, "_nrise"}, 128'(tms_q.size()), 128'(n));
    check({tag, "_tms"}, t, et);
    check({tag, "_tdi"}, d, ed);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc, n0, k;
    logic [63:0] got;
    bit          stable;

    reset = 1'b1; req_valid = 1'b0; req_ir = 1'b0; req_len = '0; req_data = '0;
    resp_ready = 1'b0; tdo_mode = 0;
    repeat (3) @(negedge clock);

    check("rst_tck", 128'(jtag_TCK), 128'(0));
    check("rst_tms", 128'(jtag_TMS), 128'(1));
    check("rst_tdi", 128'(jtag_TDI), 128'(0));
    check("rst_req_ready", 128'(req_ready), 128'(0));
    check("rst_resp_valid", 128'(resp_valid), 128'(0));
    check("rst_resp_data", 128'(resp_data), 128'(0));
    check("rst_busy", 128'(busy), 128'(1));
    check("rst_trstn", 128'(jtag_TRSTn), 128'(N_TRST > 0 ? 0 : 1));

    reset = 1'b0;
    clear_logs();
    wait_ready("tlr", 400, cyc);
    check_tlr("tlr", cyc);
    check("tck_period", 128'(rise_t[1] - rise_t[0]), 128'(4 * CLK_DIV * HALF_NS));
    check("tck_high", 128'(fall_t[0] - rise_t[0]), 128'(2 * CLK_DIV * HALF_NS));
    check("idle_tms", 128'(jtag_TMS), 128'(0));

    // DR scan, loopback
    clear_logs(); tdo_mode = 0;
    send_req(1'b0, 8, 64'hA5);
    wait_resp("dr8", 400, got);
    check_seq("dr8", 1'b0, 8, 64'hA5);
    consume("dr8");

    // IR scan, TDO held high
    wait_ready("ir5", 10, cyc);
    clear_logs(); tdo_mode = 1;
    send_req(1'b1, 5, 64'h11);
    wait_resp("ir5", 400, got);
    check_seq("ir5", 1'b1, 5, 64'h11);
    consume("ir5");

    // Zero length: response on the cycle after acceptance, no TCK
    wait_ready("len0", 10, cyc);
    clear_logs(); tdo_mode = 0;
    send_req(1'b0, 0, 64'hFFFF);
    wait_resp("len0", 0, got);
    check("len0_no_tck", 128'(tms_q.size()), 128'(0));
    consume("len0");

    // Response stall
    wait_ready("stall", 10, cyc);
    clear_logs();
    send_req(1'b0, 4, 64'h9);
    wait_resp("stall", 400, got);
    n0 = tms_q.size();
    stable = 1'b1;
    repeat (20) begin
      @(posedge clock); @(negedge clock);
      if (!resp_valid || resp_data !== got || req_ready || busy !== 1'b1) stable = 1'b0;
    end
    check("stall_stable", 128'(stable), 128'(1));
    check("stall_no_tck", 128'(tms_q.size()), 128'(n0));
    consume("stall");

    // Over-long request clamps to MAX_BITS
    wait_ready("clamp", 10, cyc);
    clear_logs();
    send_req(1'b0, 100, 64'hDEAD_BEEF_0123_4567);
    wait_resp("clamp", 1000, got);
    check_seq("clamp", 1'b0, 64, 64'hDEAD_BEEF_0123_4567);
    consume("clamp");

    // Asynchronous reset in the middle of a 64-bit shift, while TCK is high
    wait_ready("abort", 10, cyc);
    clear_logs();
    send_req(1'b0, 64, 64'h0123_4567_89AB_CDEF);
    k = 0;
    while ((tms_q.size() < 20 || !jtag_TCK) && k < 2000) begin
      @(negedge clock); k++;
    end
    check("abort_reach_shift", 128'(jtag_TCK), 128'(1));
    #1 reset = 1'b1;
    #1;
    check("abort_tck", 128'(jtag_TCK), 128'(0));
    check("abort_tms", 128'(jtag_TMS), 128'(1));
    check("abort_busy", 128'(busy), 128'(1));
    check("abort_req_ready", 128'(req_ready), 128'(0));
    check("abort_resp_data", 128'(resp_data), 128'(0));
    sb_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b0;
    clear_logs();
    wait_ready("retlr", 400, cyc);
    check_tlr("retlr", cyc);

    // Scan after the abort, TDO held low
    clear_logs(); tdo_mode = 2;
    send_req(1'b0, 3, 64'h5);
    wait_resp("post", 400, got);
    check_seq("post", 1'b0, 3, 64'h5);
    consume("post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
